// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue: circular FIFO of {PC, instruction} pairs between fetch and decode.
// Optional macro FETCH_BYPASS_EN: zero-latency pass-through of a fetched pair when the queue is empty.
module inst_prefetch_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW = 32,
    parameter int unsigned IW = 32,
    parameter logic [IW-1:0] NOP_INST = 'h00000013
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PW-1:0]              in_pc,
    input  logic [IW-1:0]              in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PW-1:0]              out_pc,
    output logic [IW-1:0]              out_inst,
    output logic                       fetch_stall,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PW-1:0] pc_mem   [DEPTH];
    logic [IW-1:0] inst_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          bypass;
    logic          push;
    logic          pop;

`ifdef FETCH_BYPASS_EN
    assign bypass = (count == '0) && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready    = (count < CW'(DEPTH));
    assign fetch_stall = ~in_ready;
    assign out_valid   = bypass || ((count != '0) && !flush);
    // A bypassed pair consumed this cycle is never written into the queue.
    assign push = in_valid && in_ready && !flush && !(bypass && out_ready);
    assign pop  = out_valid && out_ready && !bypass;

    always_comb begin
        out_pc   = '0;
        out_inst = NOP_INST;
        if (bypass) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end else if (out_valid) begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Self-checking bench for inst_prefetch_buf: directed plan plus random traffic against a queue model.
// Honours FETCH_BYPASS_EN in the reference model.
module tb_inst_prefetch_buf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW = 32;
    localparam int unsigned IW = 32;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK, RST, flush, in_valid, in_ready, out_valid, out_ready, fetch_stall;
    logic [PW-1:0] in_pc, out_pc;
    logic [IW-1:0] in_inst, out_inst;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;
    logic [63:0] model_q [$];  // {pc, inst}
    bit saw_40;

    inst_prefetch_buf #(.DEPTH(DEPTH), .PW(PW), .IW(IW), .NOP_INST(NOP)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .fetch_stall(fetch_stall), .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        assert (count <= 3'(DEPTH)) else $error("count exceeds DEPTH: %0d", count);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance the model, land at posedge+1.
    task automatic cycle(input bit fl, input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                         input bit ordy);
        bit full, byp, ov;
        logic [63:0] head;
        flush = fl; in_valid = iv; in_pc = pc; in_inst = ins; out_ready = ordy;
        @(negedge CLK);
        full = (model_q.size() == DEPTH);
        byp  = BYP && model_q.size() == 0 && iv && !fl;
        ov   = !fl && (model_q.size() != 0 || byp);
        head = byp ? {pc, ins} : (ov ? model_q[0] : {32'h0, NOP});
        check("in_ready", in_ready, !full);
        check("fetch_stall", fetch_stall, full);
        check("count", count, model_q.size());
        check("out_valid", out_valid, ov);
        check("out_pc", out_pc, head[63:32]);
        check("out_inst", out_inst, head[31:0]);
        if (ov && out_pc == 32'h40) saw_40 = 1'b1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (ov && ordy && !byp) void'(model_q.pop_front());
            if (iv && !full && !(byp && ordy)) model_q.push_back({pc, ins});
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; flush = 0; in_valid = 0; out_ready = 0; in_pc = '0; in_inst = '0;
        saw_40 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, NOP);
        check("rst_out_pc", out_pc, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        RST = 1'b0;

        // Fill, then an ignored fifth push.
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'(4 * i), 32'(8'h11 + i), 0);
        cycle(0, 1, 32'h10, 32'h15, 0);
        check("full_count", count, 4);
        // Drain in order.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("drained_count", count, 0);

        // Continuous stream across pointer wrap.
        for (int i = 0; i < 10; i++) cycle(0, 1, 32'h100 + 32'(4 * i), 32'(i), 1);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 1);

        // Flush with a coincident push of 0x40.
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h200 + 32'(4 * i), 32'(i), 0);
        cycle(1, 1, 32'h40, 32'hdead, 1);
        check("flush_count", count, 0);
        cycle(0, 1, 32'h80, 32'h80, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("flush_0x40_seen", saw_40, 0);

        // Asynchronous reset between edges.
        cycle(0, 1, 32'h300, 32'h1, 0);
        cycle(0, 1, 32'h304, 32'h2, 0);
        check("pre_rst_count", count, 2);
        #2 RST = 1'b1;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_out_valid", out_valid, 0);
        model_q.delete();
        @(posedge CLK);
        #1 RST = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
                  ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
